// File: rtl/xor_nn_pkg.sv
// xor_nn_pkg: shared FSM type, fixed-point constants and helpers for the XOR trainer.
// Define XOR_NN_TRAINER_SATURATE_EN to make fit() clamp instead of wrap.
package xor_nn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FWD_HID,
        FWD_OUT,
        BACK,
        UPDATE
    } state_e;

    localparam int FRAC = 6;
    localparam int ONE  = 1 << FRAC;
    localparam int N_W1 = 6;
    localparam int N_W2 = 3;

    // Reset weights in units of ONE
    localparam int RST_W1 [N_W1] = '{0, -1, 1, 1, 1, 1};
    localparam int RST_W2 [N_W2] = '{0, 1, -1};

    function automatic int w1_idx(input int i, input int j);
        return 2 * i + j;
    endfunction

    function automatic int w2_idx(input int k);
        return k;
    endfunction

    function automatic logic signed [63:0] fit(
        input logic signed [63:0] v,
        input int                 w
    );
`ifdef XOR_NN_TRAINER_SATURATE_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        return (v <<< (64 - w)) >>> (64 - w);
`endif
    endfunction

endpackage

// File: rtl/xor_nn_fxp_mul.sv
// xor_nn_fxp_mul: signed fixed-point multiply, full-width product
// shifted right by FRAC_BITS and truncated back to ACC_WIDTH.
module xor_nn_fxp_mul #(
    parameter int ACC_WIDTH = 26,
    parameter int FRAC_BITS = 6
) (
    input  logic signed [ACC_WIDTH-1:0] a,
    input  logic signed [ACC_WIDTH-1:0] b,
    output logic signed [ACC_WIDTH-1:0] p
);

    logic signed [2*ACC_WIDTH-1:0] prod;

    assign prod = (2*ACC_WIDTH)'(a) * (2*ACC_WIDTH)'(b);
    assign p    = ACC_WIDTH'(prod >>> FRAC_BITS);

endmodule

// File: rtl/xor_nn_trainer.sv
// xor_nn_trainer: one-sample-at-a-time SGD trainer for the 2-2-1 ReLU XOR net.
// Weight narrowing wraps unless XOR_NN_TRAINER_SATURATE_EN is defined.
module xor_nn_trainer
    import xor_nn_pkg::*;
#(
    parameter int WEIGHT_WIDTH = 12,
    parameter int FRAC_BITS    = FRAC,
    parameter int ACC_WIDTH    = 2 * WEIGHT_WIDTH + 2,
    parameter int LR_SHIFT     = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sample_valid,
    output logic                      sample_ready,
    input  logic [1:0]                sample_x,
    input  logic                      sample_target,
    input  logic                      sample_train,
    output logic                      result_valid,
    output logic [ACC_WIDTH-1:0]      result_y,
    output logic [ACC_WIDTH-1:0]      result_err,
    output logic [6*WEIGHT_WIDTH-1:0] w1_flat,
    output logic [3*WEIGHT_WIDTH-1:0] w2_flat
);

    typedef logic signed [WEIGHT_WIDTH-1:0] w_t;
    typedef logic signed [ACC_WIDTH-1:0]    acc_t;

    localparam int ONE_L = 1 << FRAC_BITS;

    state_e state, state_nxt;

    logic [1:0] x_q;
    logic       t_q;
    logic       train_q;
    w_t         w1 [N_W1];
    w_t         w2 [N_W2];
    acc_t       z_q [2];
    acc_t       h_q [2];
    acc_t       y_q, e_q;
    acc_t       g1 [N_W1];
    acc_t       g2 [N_W2];

    acc_t z_c [2];
    acc_t d_c [2];
    acc_t y_c, e_c;
    acc_t hw [2];
    acc_t eh [2];
    acc_t ew [2];

    for (genvar j = 0; j < 2; j++) begin : g_mul
        xor_nn_fxp_mul #(.ACC_WIDTH(ACC_WIDTH), .FRAC_BITS(FRAC_BITS)) u_hw (
            .a(h_q[j]), .b(acc_t'(w2[j+1])), .p(hw[j])
        );
        xor_nn_fxp_mul #(.ACC_WIDTH(ACC_WIDTH), .FRAC_BITS(FRAC_BITS)) u_eh (
            .a(e_q), .b(h_q[j]), .p(eh[j])
        );
        xor_nn_fxp_mul #(.ACC_WIDTH(ACC_WIDTH), .FRAC_BITS(FRAC_BITS)) u_ew (
            .a(e_q), .b(acc_t'(w2[j+1])), .p(ew[j])
        );
    end

    always_comb begin
        for (int j = 0; j < 2; j++) begin
            z_c[j] = acc_t'(w1[w1_idx(0, j)])
                   + (x_q[0] ? acc_t'(w1[w1_idx(1, j)]) : '0)
                   + (x_q[1] ? acc_t'(w1[w1_idx(2, j)]) : '0);
            // ReLU gate uses the pre-activation from the forward pass
            d_c[j] = (z_q[j] > 0) ? ew[j] : '0;
        end
        y_c = acc_t'(w2[0]) + hw[0] + hw[1];
        e_c = y_c - (t_q ? acc_t'(ONE_L) : '0);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (sample_valid) state_nxt = FWD_HID;
            FWD_HID: state_nxt = FWD_OUT;
            FWD_OUT: state_nxt = train_q ? BACK : IDLE;
            BACK:    state_nxt = UPDATE;
            UPDATE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            x_q          <= '0;
            t_q          <= 1'b0;
            train_q      <= 1'b0;
            y_q          <= '0;
            e_q          <= '0;
            result_valid <= 1'b0;
            for (int j = 0; j < 2; j++) begin
                z_q[j] <= '0;
                h_q[j] <= '0;
            end
            for (int k = 0; k < N_W1; k++) begin
                w1[k] <= w_t'(RST_W1[k] * ONE_L);
                g1[k] <= '0;
            end
            for (int k = 0; k < N_W2; k++) begin
                w2[k] <= w_t'(RST_W2[k] * ONE_L);
                g2[k] <= '0;
            end
        end else begin
            state        <= state_nxt;
            result_valid <= (state == FWD_OUT && !train_q) || state == UPDATE;
            unique case (state)
                IDLE: if (sample_valid) begin
                    x_q     <= sample_x;
                    t_q     <= sample_target;
                    train_q <= sample_train;
                end
                FWD_HID: for (int j = 0; j < 2; j++) begin
                    z_q[j] <= z_c[j];
                    h_q[j] <= (z_c[j] > 0) ? z_c[j] : '0;
                end
                FWD_OUT: begin
                    y_q <= y_c;
                    e_q <= e_c;
                end
                BACK: begin
                    g2[0] <= e_q;
                    for (int j = 0; j < 2; j++) begin
                        g2[j+1]           <= eh[j];
                        g1[w1_idx(0, j)] <= d_c[j];
                        g1[w1_idx(1, j)] <= x_q[0] ? d_c[j] : '0;
                        g1[w1_idx(2, j)] <= x_q[1] ? d_c[j] : '0;
                    end
                end
                UPDATE: begin
                    for (int k = 0; k < N_W1; k++)
                        w1[k] <= w_t'(fit(64'(acc_t'(w1[k]) - (g1[k] >>> LR_SHIFT)),
                                          WEIGHT_WIDTH));
                    for (int k = 0; k < N_W2; k++)
                        w2[k] <= w_t'(fit(64'(acc_t'(w2[k]) - (g2[k] >>> LR_SHIFT)),
                                          WEIGHT_WIDTH));
                end
                default: ;
            endcase
        end
    end

    assign sample_ready = (state == IDLE);
    assign result_y     = y_q;
    assign result_err   = e_q;

    for (genvar i = 0; i < 3; i++) begin : g_w1
        for (genvar j = 0; j < 2; j++) begin : g_col
            assign w1_flat[w1_idx(i, j)*WEIGHT_WIDTH +: WEIGHT_WIDTH] = w1[w1_idx(i, j)];
        end
    end

    for (genvar k = 0; k < 3; k++) begin : g_w2
        assign w2_flat[w2_idx(k)*WEIGHT_WIDTH +: WEIGHT_WIDTH] = w2[w2_idx(k)];
    end

endmodule
